// File: rtl/cal_pkg.sv
// Shared calendar constants, field widths and the Gregorian leap-year rule.
package cal_pkg;

  localparam int DOW_W   = 3;
  localparam int DATE_W  = 5;
  localparam int MONTH_W = 4;

  localparam logic [MONTH_W-1:0] JAN = 4'd0;
  localparam logic [MONTH_W-1:0] FEB = 4'd1;
  localparam logic [MONTH_W-1:0] MAR = 4'd2;
  localparam logic [MONTH_W-1:0] APR = 4'd3;
  localparam logic [MONTH_W-1:0] MAY = 4'd4;
  localparam logic [MONTH_W-1:0] JUN = 4'd5;
  localparam logic [MONTH_W-1:0] JUL = 4'd6;
  localparam logic [MONTH_W-1:0] AUG = 4'd7;
  localparam logic [MONTH_W-1:0] SEP = 4'd8;
  localparam logic [MONTH_W-1:0] OCT = 4'd9;
  localparam logic [MONTH_W-1:0] NOV = 4'd10;
  localparam logic [MONTH_W-1:0] DEC = 4'd11;

  localparam logic [DOW_W-1:0]  DOW_MAX      = 3'd6;
  localparam logic [DATE_W-1:0] LEN_LONG     = 5'd31;
  localparam logic [DATE_W-1:0] LEN_SHORT    = 5'd30;
  localparam logic [DATE_W-1:0] LEN_FEB      = 5'd28;
  localparam logic [DATE_W-1:0] LEN_FEB_LEAP = 5'd29;

  // Callers zero-extend their year to 32 bits, so the rule sees the full value.
  function automatic logic is_leap(input logic [31:0] year);
    return (year[1:0] == 2'd0) &&
           ((year % 32'd100 != 32'd0) || (year % 32'd400 == 32'd0));
  endfunction

endpackage

// File: rtl/cal_gregorian_if.sv
// Load request and calendar outputs of cal_gregorian, grouped as one bundle.
// Loads are single-cycle strobes: ld_valid qualifies the ld_* fields in the
// cycle it is high, and there is no ready, so the design answers each load in
// that same cycle (accept, or flag ld_err one cycle later).
interface cal_gregorian_if #(
  parameter int YEAR_W = 12
);
  import cal_pkg::*;

  logic               en;
  logic               ld_valid;
  logic [DOW_W-1:0]   ld_day;
  logic [DATE_W-1:0]  ld_date;
  logic [MONTH_W-1:0] ld_month;
  logic [YEAR_W-1:0]  ld_year;
  logic [DOW_W-1:0]   day;
  logic [DATE_W-1:0]  date;
  logic [MONTH_W-1:0] month;
  logic [YEAR_W-1:0]  year;
  logic               day_tick;
  logic               new_month;
  logic               new_year;
  logic               ld_err;

  modport master (
    output en, ld_valid, ld_day, ld_date, ld_month, ld_year,
    input  day, date, month, year, day_tick, new_month, new_year, ld_err
  );

  modport slave (
    input  en, ld_valid, ld_day, ld_date, ld_month, ld_year,
    output day, date, month, year, day_tick, new_month, new_year, ld_err
  );

endinterface

// File: rtl/cal_dim.sv
// Days in a given month of a given year; purely combinational.
module cal_dim
  import cal_pkg::*;
#(
  parameter int YEAR_W  = 12,
  parameter int LEAP_EN = 1
) (
  input  logic [MONTH_W-1:0] month,
  input  logic [YEAR_W-1:0]  year,
  output logic [DATE_W-1:0]  dim
);

  logic leap;

  always_comb begin
    leap = (LEAP_EN != 0) && is_leap(32'(year));
    dim  = LEN_LONG;
    case (month)
      APR, JUN, SEP, NOV: dim = LEN_SHORT;
      FEB:                dim = leap ? LEN_FEB_LEAP : LEN_FEB;
      default:            dim = LEN_LONG;
    endcase
  end

endmodule

// File: rtl/cal_gregorian.sv
// Day/date/month/year calendar counter with prescaled day advance, validated
// load and registered rollover strobes.
module cal_gregorian
  import cal_pkg::*;
#(
  parameter int YEAR_W    = 12,
  parameter int BASE_YEAR = 2000,
  parameter int LEAP_EN   = 1,
  parameter int TICK_DIV  = 1
) (
  input logic             clk,
  input logic             rst_n,
  cal_gregorian_if.slave  bus
);

  localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]   pre_q;
  logic [DOW_W-1:0]   day_q;
  logic [DATE_W-1:0]  date_q;
  logic [MONTH_W-1:0] month_q;
  logic [YEAR_W-1:0]  year_q;
  logic               day_tick_q, new_month_q, new_year_q, ld_err_q;

  logic [DATE_W-1:0]  cur_dim, ld_dim;
  logic               advance, ld_ok, ld_bad, month_end, year_end;

  cal_dim #(.YEAR_W(YEAR_W), .LEAP_EN(LEAP_EN)) u_cur_dim (
    .month (month_q),
    .year  (year_q),
    .dim   (cur_dim)
  );

  cal_dim #(.YEAR_W(YEAR_W), .LEAP_EN(LEAP_EN)) u_ld_dim (
    .month (bus.ld_month),
    .year  (bus.ld_year),
    .dim   (ld_dim)
  );

  always_comb begin
    advance   = bus.en && (pre_q == PRE_LAST);
    ld_ok     = bus.ld_valid && (bus.ld_day <= DOW_MAX) && (bus.ld_month <= DEC) &&
                (bus.ld_date != '0) && (bus.ld_date <= ld_dim);
    ld_bad    = bus.ld_valid && !ld_ok;
    month_end = (date_q == cur_dim);
    year_end  = month_end && (month_q == DEC);
  end

  // An accepted load takes priority over an advance in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      day_q   <= '0;
      date_q  <= 5'd1;
      month_q <= JAN;
      year_q  <= YEAR_W'(BASE_YEAR);
    end else if (ld_ok) begin
      pre_q   <= '0;
      day_q   <= bus.ld_day;
      date_q  <= bus.ld_date;
      month_q <= bus.ld_month;
      year_q  <= bus.ld_year;
    end else if (bus.en) begin
      pre_q <= advance ? '0 : pre_q + PRE_W'(1);
      if (advance) begin
        day_q <= (day_q == DOW_MAX) ? '0 : day_q + 3'd1;
        if (!month_end) begin
          date_q <= date_q + 5'd1;
        end else begin
          date_q  <= 5'd1;
          month_q <= year_end ? JAN : month_q + 4'd1;
          if (year_end) year_q <= year_q + YEAR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_tick_q  <= 1'b0;
      new_month_q <= 1'b0;
      new_year_q  <= 1'b0;
      ld_err_q    <= 1'b0;
    end else begin
      day_tick_q  <= advance && !ld_ok;
      new_month_q <= advance && !ld_ok && month_end;
      new_year_q  <= advance && !ld_ok && year_end;
      ld_err_q    <= ld_bad;
    end
  end

  assign bus.day       = day_q;
  assign bus.date      = date_q;
  assign bus.month     = month_q;
  assign bus.year      = year_q;
  assign bus.day_tick  = day_tick_q;
  assign bus.new_month = new_month_q;
  assign bus.new_year  = new_year_q;
  assign bus.ld_err    = ld_err_q;

endmodule

// File: tb/tb_cal_gregorian.sv
// Directed bench for cal_gregorian: three instances cover TICK_DIV=1 with and
// without the leap rule, and TICK_DIV=4.
module tb_cal_gregorian;
  import cal_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cal_gregorian_if #(.YEAR_W(12)) ia ();
  cal_gregorian_if #(.YEAR_W(12)) ib ();
  cal_gregorian_if #(.YEAR_W(12)) ic ();

  // The LEAP_EN=0 instance sees exactly the same stimulus as the main one.
  assign ib.en       = ia.en;
  assign ib.ld_valid = ia.ld_valid;
  assign ib.ld_day   = ia.ld_day;
  assign ib.ld_date  = ia.ld_date;
  assign ib.ld_month = ia.ld_month;
  assign ib.ld_year  = ia.ld_year;

  cal_gregorian #(.YEAR_W(12), .BASE_YEAR(2000), .LEAP_EN(1), .TICK_DIV(1)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (ia.slave));
  cal_gregorian #(.YEAR_W(12), .BASE_YEAR(2000), .LEAP_EN(0), .TICK_DIV(1)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (ib.slave));
  cal_gregorian #(.YEAR_W(12), .BASE_YEAR(2000), .LEAP_EN(1), .TICK_DIV(4)) dut_c (
    .clk (clk), .rst_n (rst_n), .bus (ic.slave));

  // State packed as {day, date, month, year}; flags as {day_tick, new_month, new_year, ld_err}.
  logic [23:0] st_a, st_b, st_c;
  logic [3:0]  fl_a, fl_c;
  assign st_a = {ia.day, ia.date, ia.month, ia.year};
  assign st_b = {ib.day, ib.date, ib.month, ib.year};
  assign st_c = {ic.day, ic.date, ic.month, ic.year};
  assign fl_a = {ia.day_tick, ia.new_month, ia.new_year, ia.ld_err};
  assign fl_c = {ic.day_tick, ic.new_month, ic.new_year, ic.ld_err};

  localparam logic [23:0] RST_ST = {3'd0, 5'd1, 4'd0, 12'd2000};

  task automatic load_a(input logic [23:0] v);
    ia.ld_valid = 1'b1;
    {ia.ld_day, ia.ld_date, ia.ld_month, ia.ld_year} = v;
    @(negedge clk);
    ia.ld_valid = 1'b0;
  endtask

  task automatic tick_a();
    ia.en = 1'b1;
    @(negedge clk);
    ia.en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++; if (st_a !== RST_ST) begin fails++; $display("FAIL reset_in_st got=%h exp=%h", st_a, RST_ST); end
    tests++; if (fl_a !== 4'b0) begin fails++; $display("FAIL reset_in_fl got=%b exp=0000", fl_a); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (st_a !== RST_ST) begin fails++; $display("FAIL reset_out_st_a got=%h exp=%h", st_a, RST_ST); end
    tests++; if (st_c !== RST_ST) begin fails++; $display("FAIL reset_out_st_c got=%h exp=%h", st_c, RST_ST); end
    tests++; if (fl_c !== 4'b0) begin fails++; $display("FAIL reset_out_fl_c got=%b exp=0000", fl_c); end
  endtask

  task automatic test_month_walk();
    logic [23:0] exp;
    int nm_cnt = 0;
    ia.en = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      exp = (k < 31) ? {3'(k % 7), 5'(k + 1), 4'd0, 12'd2000} : {3'd3, 5'd1, 4'd1, 12'd2000};
      if (ia.new_month) nm_cnt++;
      tests++; if (st_a !== exp) begin fails++; $display("FAIL walk_st k=%0d got=%h exp=%h", k, st_a, exp); end
      tests++; if (ia.day_tick !== 1'b1) begin fails++; $display("FAIL walk_tick k=%0d got=%b exp=1", k, ia.day_tick); end
    end
    ia.en = 1'b0;
    tests++; if (nm_cnt != 1) begin fails++; $display("FAIL walk_new_month_count got=%0d exp=1", nm_cnt); end
    @(negedge clk);
    tests++; if (fl_a !== 4'b0) begin fails++; $display("FAIL walk_idle_fl got=%b exp=0000", fl_a); end
    tests++; if (st_a !== {3'd3, 5'd1, 4'd1, 12'd2000}) begin fails++; $display("FAIL walk_hold got=%h", st_a); end
  endtask

  task automatic test_leap();
    load_a({3'd2, 5'd28, 4'd1, 12'd2023});
    tests++; if (st_a !== {3'd2, 5'd28, 4'd1, 12'd2023}) begin fails++; $display("FAIL load_2023 got=%h", st_a); end
    tests++; if (fl_a !== 4'b0) begin fails++; $display("FAIL load_2023_fl got=%b exp=0000", fl_a); end
    tick_a();
    tests++; if (st_a !== {3'd3, 5'd1, 4'd2, 12'd2023}) begin fails++; $display("FAIL feb_2023 got=%h exp=%h", st_a, {3'd3, 5'd1, 4'd2, 12'd2023}); end
    tests++; if (fl_a !== 4'b1100) begin fails++; $display("FAIL feb_2023_fl got=%b exp=1100", fl_a); end
    load_a({3'd3, 5'd28, 4'd1, 12'd2024});
    tick_a();
    tests++; if (st_a !== {3'd4, 5'd29, 4'd1, 12'd2024}) begin fails++; $display("FAIL feb28_2024 got=%h", st_a); end
    tests++; if (fl_a !== 4'b1000) begin fails++; $display("FAIL feb28_2024_fl got=%b exp=1000", fl_a); end
    tick_a();
    tests++; if (st_a !== {3'd5, 5'd1, 4'd2, 12'd2024}) begin fails++; $display("FAIL feb29_2024 got=%h", st_a); end
    tests++; if (fl_a !== 4'b1100) begin fails++; $display("FAIL feb29_2024_fl got=%b exp=1100", fl_a); end
    load_a({3'd0, 5'd28, 4'd1, 12'd1900});
    tick_a();
    tests++; if (st_a !== {3'd1, 5'd1, 4'd2, 12'd1900}) begin fails++; $display("FAIL feb_1900 got=%h", st_a); end
    load_a({3'd1, 5'd28, 4'd1, 12'd2000});
    tick_a();
    tests++; if (st_a !== {3'd2, 5'd29, 4'd1, 12'd2000}) begin fails++; $display("FAIL feb_2000 got=%h", st_a); end
    tests++; if (st_b !== {3'd2, 5'd1, 4'd2, 12'd2000}) begin fails++; $display("FAIL feb_2000_noleap got=%h", st_b); end
    load_a({3'd5, 5'd29, 4'd1, 12'd0});
    tests++; if (st_a !== {3'd5, 5'd29, 4'd1, 12'd0}) begin fails++; $display("FAIL load_feb29_y0 got=%h", st_a); end
    tests++; if (ia.ld_err !== 1'b0) begin fails++; $display("FAIL load_feb29_y0_err got=%b exp=0", ia.ld_err); end
  endtask

  task automatic test_year_wrap();
    load_a({3'd6, 5'd31, 4'd11, 12'd2024});
    tick_a();
    tests++; if (st_a !== {3'd0, 5'd1, 4'd0, 12'd2025}) begin fails++; $display("FAIL dec_2024 got=%h", st_a); end
    tests++; if (fl_a !== 4'b1110) begin fails++; $display("FAIL dec_2024_fl got=%b exp=1110", fl_a); end
    load_a({3'd4, 5'd31, 4'd11, 12'd4095});
    tick_a();
    tests++; if (st_a !== {3'd5, 5'd1, 4'd0, 12'd0}) begin fails++; $display("FAIL wrap_4095 got=%h", st_a); end
    tests++; if (fl_a !== 4'b1110) begin fails++; $display("FAIL wrap_4095_fl got=%b exp=1110", fl_a); end
  endtask

  task automatic test_load_err();
    logic [23:0] bad [6];
    logic [23:0] keep;
    bad = '{{3'd3, 5'd30, 4'd1, 12'd2024},   // Feb 30
            {3'd3, 5'd10, 4'd12, 12'd2024},  // month 12
            {3'd3, 5'd0, 4'd5, 12'd2024},    // date 0
            {3'd7, 5'd10, 4'd5, 12'd2024},   // day 7
            {3'd3, 5'd29, 4'd1, 12'd2023},   // Feb 29, non-leap
            {3'd3, 5'd31, 4'd3, 12'd2024}};  // Apr 31
    keep = st_a;
    for (int i = 0; i < 6; i++) begin
      load_a(bad[i]);
      tests++; if (st_a !== keep) begin fails++; $display("FAIL bad_load_st i=%0d got=%h exp=%h", i, st_a, keep); end
      tests++; if (fl_a !== 4'b0001) begin fails++; $display("FAIL bad_load_err i=%0d got=%b exp=0001", i, fl_a); end
      @(negedge clk);
      tests++; if (ia.ld_err !== 1'b0) begin fails++; $display("FAIL bad_load_pulse i=%0d got=%b exp=0", i, ia.ld_err); end
    end
  endtask

  task automatic test_load_vs_advance();
    ia.en = 1'b1;
    ia.ld_valid = 1'b1;
    {ia.ld_day, ia.ld_date, ia.ld_month, ia.ld_year} = {3'd2, 5'd15, 4'd6, 12'd2030};
    @(negedge clk);
    tests++; if (st_a !== {3'd2, 5'd15, 4'd6, 12'd2030}) begin fails++; $display("FAIL coinc_ok_st got=%h", st_a); end
    tests++; if (fl_a !== 4'b0) begin fails++; $display("FAIL coinc_ok_fl got=%b exp=0000", fl_a); end
    ia.ld_day = 3'd7;
    @(negedge clk);
    ia.en = 1'b0;
    ia.ld_valid = 1'b0;
    tests++; if (st_a !== {3'd3, 5'd16, 4'd6, 12'd2030}) begin fails++; $display("FAIL coinc_bad_st got=%h", st_a); end
    tests++; if (fl_a !== 4'b1001) begin fails++; $display("FAIL coinc_bad_fl got=%b exp=1001", fl_a); end
  endtask

  task automatic test_prescaler();
    logic [5:0] pat;
    pat = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      ic.en = pat[i];
      @(negedge clk);
      tests++; if (st_c !== RST_ST || ic.day_tick !== 1'b0) begin fails++; $display("FAIL pre_hold i=%0d got=%h/%b exp=%h/0", i, st_c, ic.day_tick, RST_ST); end
    end
    ic.en = 1'b1;
    @(negedge clk);
    ic.en = 1'b0;
    tests++; if (st_c !== {3'd1, 5'd2, 4'd0, 12'd2000}) begin fails++; $display("FAIL pre_adv got=%h", st_c); end
    tests++; if (fl_c !== 4'b1000) begin fails++; $display("FAIL pre_adv_fl got=%b exp=1000", fl_c); end
    @(negedge clk);
    tests++; if (ic.day_tick !== 1'b0) begin fails++; $display("FAIL pre_tick_once got=%b exp=0", ic.day_tick); end
  endtask

  task automatic test_reset_mid();
    ic.en = 1'b1;
    repeat (2) @(negedge clk);
    ia.en = 1'b1;
    @(posedge clk);
    #2;
    ia.en = 1'b0;
    tests++; if (ia.day_tick !== 1'b1) begin fails++; $display("FAIL mid_pre_tick got=%b exp=1", ia.day_tick); end
    rst_n = 1'b0;
    #1;
    tests++; if (st_a !== RST_ST || fl_a !== 4'b0) begin fails++; $display("FAIL mid_rst_a got=%h/%b exp=%h/0000", st_a, fl_a, RST_ST); end
    tests++; if (st_c !== {3'd0, 5'd1, 4'd0, 12'd2000}) begin fails++; $display("FAIL mid_rst_c got=%h exp=%h", st_c, RST_ST); end
    ic.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      tests++; if (fl_a !== 4'b0 || fl_c !== 4'b0) begin fails++; $display("FAIL post_rst_strobe got=%b/%b exp=0000", fl_a, fl_c); end
    end
    ic.en = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (st_c !== RST_ST) begin fails++; $display("FAIL post_rst_pre got=%h exp=%h", st_c, RST_ST); end
    @(negedge clk);
    ic.en = 1'b0;
    tests++; if (st_c !== {3'd1, 5'd2, 4'd0, 12'd2000} || ic.day_tick !== 1'b1) begin fails++; $display("FAIL post_rst_adv got=%h/%b", st_c, ic.day_tick); end
  endtask

  initial begin
    ia.en = 1'b0; ia.ld_valid = 1'b0;
    {ia.ld_day, ia.ld_date, ia.ld_month, ia.ld_year} = '0;
    ic.en = 1'b0; ic.ld_valid = 1'b0;
    {ic.ld_day, ic.ld_date, ic.ld_month, ic.ld_year} = '0;
    test_reset();
    test_month_walk();
    test_leap();
    test_year_wrap();
    test_load_err();
    test_load_vs_advance();
    test_prescaler();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
